// File: rtl/ft2232_device_emu.sv
// Device-side emulation of the FT2232H 245 synchronous FIFO (channel A), with host-side valid/ready streams.
// Optional flag stalling is enabled by defining FT_EMU_STALL_EN.
module ft2232_device_emu #(
    parameter int          RX_DEPTH_LOG2 = 4,
    parameter int          TX_DEPTH_LOG2 = 4,
    parameter logic [15:0] STALL_SEED    = 16'hACE1
) (
    input  logic       fifo_clk_i,
    input  logic       reset_n_i,
    input  logic       ft_reset_n_i,
    input  logic       fifo_rd_n_i,
    input  logic       fifo_wr_n_i,
    input  logic       fifo_oe_n_i,
    output logic       fifo_rxf_n_o,
    output logic       fifo_txe_n_o,
    input  logic [7:0] fifo_data_i,
    output logic [7:0] fifo_data_o,
    output logic       fifo_data_oe_o,
    input  logic       host_rx_valid_i,
    input  logic [7:0] host_rx_data_i,
    output logic       host_rx_ready_o,
    output logic       host_tx_valid_o,
    output logic [7:0] host_tx_data_o,
    input  logic       host_tx_ready_i,
    output logic [2:0] err_o,
    input  logic       err_clr_i
);

    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam logic [RX_DEPTH_LOG2:0] RX_FULL = (RX_DEPTH_LOG2 + 1)'(RX_DEPTH);
    localparam logic [TX_DEPTH_LOG2:0] TX_FULL = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);

    if (STALL_SEED == 16'h0000) begin : g_seed_check
        $error("STALL_SEED must be nonzero");
    end
    if (RX_DEPTH_LOG2 < 1 || TX_DEPTH_LOG2 < 1) begin : g_depth_check
        $error("buffer depths must be at least 2");
    end

    logic [7:0] rx_mem [RX_DEPTH];
    logic [7:0] tx_mem [TX_DEPTH];

    logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [RX_DEPTH_LOG2:0]   rx_count, rx_count_next;
    logic [TX_DEPTH_LOG2:0]   tx_count, tx_count_next;
    logic                     rxf_n_q, txe_n_q, rxf_n_d, txe_n_d;
    logic [2:0]               err_q, err_d, err_event;
    logic                     stall;

    logic rd_req, wr_req, oe_act, run;
    logic rx_pop, tx_push, host_rx_push, host_tx_pop;

`ifdef FT_EMU_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) lfsr <= STALL_SEED;
        else            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // The mask rides on top of the registered flags, so a stalled cycle looks exactly like empty/full.
    assign stall = (lfsr[3:0] == 4'h0);
`else
    assign stall = 1'b0;
`endif

    assign fifo_rxf_n_o   = rxf_n_q | stall;
    assign fifo_txe_n_o   = txe_n_q | stall;
    assign fifo_data_oe_o = ~fifo_oe_n_i;
    assign fifo_data_o    = rx_mem[rx_rd_ptr];
    assign host_tx_data_o = tx_mem[tx_rd_ptr];
    assign err_o          = err_q;

    assign rd_req = ~fifo_rd_n_i;
    assign wr_req = ~fifo_wr_n_i;
    assign oe_act = ~fifo_oe_n_i;
    assign run    = ft_reset_n_i;

    assign host_rx_ready_o = run & (rx_count != RX_FULL);
    assign host_tx_valid_o = run & (tx_count != '0);
    assign host_rx_push    = host_rx_valid_i & host_rx_ready_o;
    assign host_tx_pop     = host_tx_valid_o & host_tx_ready_i;

    // Master transfers are gated by the flags the master actually sees, stall mask included.
    assign rx_pop  = run & rd_req & oe_act & ~fifo_rxf_n_o;
    assign tx_push = run & wr_req & ~fifo_txe_n_o & ~oe_act & ~rd_req;

    assign err_event[0] = rd_req & fifo_rxf_n_o;
    assign err_event[1] = wr_req & fifo_txe_n_o;
    assign err_event[2] = (rd_req & ~oe_act) | (wr_req & (oe_act | rd_req));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rx_count_next = rx_count;
        tx_count_next = tx_count;
        err_d         = err_q;
        if (run) begin
            if (host_rx_push && !rx_pop)      rx_count_next = rx_count + (RX_DEPTH_LOG2 + 1)'(1);
            else if (!host_rx_push && rx_pop) rx_count_next = rx_count - (RX_DEPTH_LOG2 + 1)'(1);
            if (tx_push && !host_tx_pop)      tx_count_next = tx_count + (TX_DEPTH_LOG2 + 1)'(1);
            else if (!tx_push && host_tx_pop) tx_count_next = tx_count - (TX_DEPTH_LOG2 + 1)'(1);
            err_d = (err_clr_i ? 3'b000 : err_q) | err_event;
        end else begin
            rx_count_next = '0;
            tx_count_next = '0;
        end
        rxf_n_d = ~run | (rx_count_next == '0);
        txe_n_d = ~run | (tx_count_next == TX_FULL);
    end

    always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset_n_i) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_count  <= '0;
            tx_count  <= '0;
            rxf_n_q   <= 1'b1;
            txe_n_q   <= 1'b1;
            err_q     <= 3'b000;
        end else begin
            rx_count <= rx_count_next;
            tx_count <= tx_count_next;
            rxf_n_q  <= rxf_n_d;
            txe_n_q  <= txe_n_d;
            err_q    <= err_d;
            if (!run) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
            end else begin
                if (host_rx_push) rx_wr_ptr <= rx_wr_ptr + RX_DEPTH_LOG2'(1);
                if (rx_pop)       rx_rd_ptr <= rx_rd_ptr + RX_DEPTH_LOG2'(1);
                if (tx_push)      tx_wr_ptr <= tx_wr_ptr + TX_DEPTH_LOG2'(1);
                if (host_tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_DEPTH_LOG2'(1);
            end
        end
    end

    // NOTE: buffer storage is deliberately not reset; emptiness is tracked by pointers and counts alone.
    always_ff @(posedge fifo_clk_i) begin
        if (host_rx_push) rx_mem[rx_wr_ptr] <= host_rx_data_i;
        if (tx_push)      tx_mem[tx_wr_ptr] <= fifo_data_i;
    end

endmodule
